dsp_mul_seq: RTL and testbench

DSP_MUL_SEQ -- requirements
Module: dsp_mul_seq

---
 rtl/dsp_mul_seq_pkg.sv | 18 +
 rtl/dsp_mul_seq.sv | 102 ++++++++++
 tb/tb_dsp_mul_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mul_seq_pkg.sv
// dsp_mul_seq_pkg: shared width, state encoding and iteration-counter width
// for the sequential shift-add multiplier.
`default_nettype none

package dsp_mul_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dsp_mul_seq.sv
// dsp_mul_seq: 32-iteration shift-add multiplier (low word) driving an external add/sub unit.
// Optional macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
`default_nettype none

module dsp_mul_seq #(
  parameter int XLEN = dsp_mul_seq_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_in1,
  output logic [XLEN-1:0] add_in2,
  output logic            add_sub,
  input  logic [XLEN-1:0] add_out
);

  import dsp_mul_seq_pkg::*;

  state_t             state;
  state_t             state_nxt;
  logic [XLEN-1:0]    acc;
  logic [XLEN-1:0]    mcand;
  logic [XLEN-1:0]    mplier;
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               last_iter;
  logic               zero_mplier_start;

  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef EARLY_TERM_EN
  assign last_iter         = (count == {CNT_W{1'b1}}) || (mplier[XLEN-1:1] == '0);
  assign zero_mplier_start = (op_b == '0);
`else
  assign last_iter         = (count == {CNT_W{1'b1}});
  assign zero_mplier_start = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)
          state_nxt = zero_mplier_start ? DONE : RUN;
        else
          state_nxt = IDLE;
      end
      RUN:     if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // The adder is shared with the rest of the datapath, so keep its inputs quiet outside RUN.
  always_comb begin
    add_in1 = '0;
    add_in2 = '0;
    add_sub = 1'b0;
    if (state == RUN) begin
      add_in1 = acc;
      add_in2 = mplier[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        count  <= '0;
        if (zero_mplier_start)
          result <= '0;
      end else if (state == RUN) begin
        acc    <= add_out;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (last_iter)
          result <= add_out;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_dsp_mul_seq.sv
// tb_dsp_mul_seq: scoreboard bench for dsp_mul_seq with a behavioural model of the external adder.
`default_nettype none

module tb_dsp_mul_seq;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic        add_sub;
  logic [31:0] add_out;

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign add_out = add_sub ? (add_in1 - add_in2) : (add_in1 + add_in2);

  dsp_mul_seq #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .add_in1 (add_in1),
    .add_in2 (add_in2),
    .add_sub (add_sub),
    .add_out (add_out)
  );

  function automatic int exp_lat(input logic [31:0] b);
`ifdef EARLY_TERM_EN
    int hi = -1;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return hi + 2;
`else
    return 33;
`endif
  endfunction

  // Call at a negedge: start is sampled on the next rising edge (cycle 0).
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    e.res = a * b;
    e.lat = exp_lat(b);
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int lat, output logic [31:0] res, output bit ok);
    ok  = 1'b0;
    lat = -1;
    res = 'x;
    for (int n = n0; n < 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        res = result;
        ok  = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_op(input string name, input int n0);
    int          lat;
    logic [31:0] res;
    bit          ok;
    exp_t        e;
    wait_done(n0, lat, res, ok);
    e = sb.pop_front();
    total++;
    if (!ok) $display("FAIL %s timeout: no done within budget, required latency %0d", name, e.lat);
    else if (res !== e.res) $display("FAIL %s result: got %h required %h", name, res, e.res);
    else passed++;
    total++;
    if (lat !== e.lat) $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
    else passed++;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h1234_5678;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, result, add_in1, add_in2, add_sub} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b result=%h in1=%h in2=%h sub=%b required all zero",
               busy, done, result, add_in1, add_in2, add_sub);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, add_in1, add_in2, add_sub} !== '0)
      $display("FAIL idle_adder_quiet: got busy=%b done=%b in1=%h in2=%h sub=%b required zero",
               busy, done, add_in1, add_in2, add_sub);
    else passed++;
  endtask

  task automatic test_basic;
    logic [31:0] av[6] = '{32'd3, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h0, 32'h0};
    logic [31:0] bv[6] = '{32'd5, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 3; i < 6; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom >> (i * 7);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(av[i], bv[i]);
      if (i == 0) begin
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || add_sub !== 1'b0 || add_in2 !== 32'd3)
          $display("FAIL run_first_cycle: got busy=%b sub=%b in2=%h required 1 0 00000003", busy, add_sub, add_in2);
        else passed++;
        check_op($sformatf("mul%0d", i), 2);
      end else begin
        check_op($sformatf("mul%0d", i), 1);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL done_pulse%0d: got done=%b busy=%b required 0 0", i, done, busy);
      else passed++;
    end
  endtask

  task automatic test_ignore_start;
    int          lat;
    logic [31:0] res;
    bit          ok;
`ifdef EARLY_TERM_EN
    int inj = 3;
`else
    int inj = 5;
`endif
    @(negedge clk);
    issue(32'd7, 32'd9);
    for (int n = 1; n < inj; n++) @(negedge clk);
    start = 1'b1;
    op_a  = 32'd2;
    op_b  = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(inj, lat, res, ok);
    void'(sb.pop_front());
    total++;
    if (!ok || res !== 32'd63 || lat !== exp_lat(32'd9))
      $display("FAIL ignore_start: got ok=%b result=%0d latency=%0d required result 63 latency %0d",
               ok, res, lat, exp_lat(32'd9));
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ignore_start_idle: got busy=%b done=%b required 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    bit saw_done = 1'b0;
    @(negedge clk);
    issue(32'd7, 32'hFFFF_0000);
    for (int n = 1; n < 10; n++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    void'(sb.pop_front());
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || add_in1 !== 32'd0 || add_in2 !== 32'd0)
      $display("FAIL reset_abort: got busy=%b done=%b result=%h in1=%h in2=%h required zeros",
               busy, done, result, add_in1, add_in2);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) $display("FAIL no_done_after_abort: got activity after reset required none");
    else passed++;
    issue(32'd6, 32'd7);
    check_op("after_reset_6x7", 1);
  endtask

  task automatic test_back_to_back;
    int          lat;
    logic [31:0] res;
    bit          ok;
    exp_t        e;
    @(negedge clk);
    issue(32'd4, 32'd4);
    wait_done(1, lat, res, ok);
    e = sb.pop_front();
    total++;
    if (!ok || res !== 32'd16 || lat !== e.lat)
      $display("FAIL b2b_first: got ok=%b result=%0d latency=%0d required 16 latency %0d", ok, res, lat, e.lat);
    else passed++;
    issue(32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_handover: got done=%b busy=%b required 0 1", done, busy);
    else passed++;
    check_op("b2b_wrap", 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
